// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM state encodings, master ids and default bus widths
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    localparam logic MID_IFU = 1'b0;
    localparam logic MID_LSU = 1'b1;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

endpackage

// File: rtl/arb_pick2.sv
// arb_pick2: combinational two-way winner selection for the memory bus arbiter
module arb_pick2
    import bus_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic       winner
);

    // a tie goes away from the last winner (round robin) or to the LSU (fixed priority)
    always_comb begin
        winner = &req ? (RR_EN ? ~rr_last : MID_LSU) : (req[1] ? MID_LSU : MID_IFU);
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory slave port between the fetch (M0) and load/store (M1) masters
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter bit RR_EN = 1'b1,
    parameter int AW    = BUS_AW,
    parameter int DW    = BUS_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req_valid,
    output logic            m0_req_ready,
    input  logic [AW-1:0]   m0_addr,
    input  logic            m0_wen,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    output logic            m0_resp_valid,
    input  logic            m0_resp_ready,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_req_valid,
    output logic            m1_req_ready,
    input  logic [AW-1:0]   m1_addr,
    input  logic            m1_wen,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    output logic            m1_resp_valid,
    input  logic            m1_resp_ready,
    output logic [DW-1:0]   m1_rdata,
    output logic            s_req_valid,
    input  logic            s_req_ready,
    output logic [AW-1:0]   s_addr,
    output logic            s_wen,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    input  logic            s_resp_valid,
    output logic            s_resp_ready,
    input  logic [DW-1:0]   s_rdata,
    output logic            busy,
    output logic            owner,
    output logic            err_stray
);

    state_t state, state_nx;
    logic   owner_nx, rr_last, rr_last_nx, err_nx, win;
    logic   own_req_valid, own_resp_ready, in_grant, in_wait;

    arb_pick2 #(.RR_EN(RR_EN)) u_pick (
        .req    ({m1_req_valid, m0_req_valid}),
        .rr_last(rr_last),
        .winner (win)
    );

    // state, owner, round-robin history and the sticky stray-response flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= MID_IFU;
            rr_last   <= MID_LSU;
            err_stray <= 1'b0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            rr_last   <= rr_last_nx;
            err_stray <= err_nx;
        end
    end

    // next state: arbitrate in IDLE, hold the owner until its response handshake completes
    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        rr_last_nx = rr_last;
        err_nx     = err_stray | (s_resp_valid && state != WAIT_RESP);
        if (state == IDLE && (m0_req_valid || m1_req_valid)) begin
            state_nx   = GRANT;
            owner_nx   = win;
            rr_last_nx = win;
        end else if (state == GRANT && !own_req_valid) begin
            state_nx = IDLE;
        end else if (state == GRANT && s_req_ready) begin
            state_nx = WAIT_RESP;
        end else if (state == WAIT_RESP && s_resp_valid && own_resp_ready) begin
            state_nx = IDLE;
        end
    end

    // owner-steered request/response muxes; the non-owner only ever sees zeros
    always_comb begin
        in_grant       = state == GRANT;
        in_wait        = state == WAIT_RESP;
        own_req_valid  = owner ? m1_req_valid : m0_req_valid;
        own_resp_ready = owner ? m1_resp_ready : m0_resp_ready;
        s_req_valid    = in_grant && own_req_valid;
        s_addr         = owner ? m1_addr : m0_addr;
        s_wen          = owner ? m1_wen : m0_wen;
        s_wdata        = owner ? m1_wdata : m0_wdata;
        s_wstrb        = owner ? m1_wstrb : m0_wstrb;
        m0_req_ready   = in_grant && owner == MID_IFU && s_req_ready;
        m1_req_ready   = in_grant && owner == MID_LSU && s_req_ready;
        m0_resp_valid  = in_wait && owner == MID_IFU && s_resp_valid;
        m1_resp_valid  = in_wait && owner == MID_LSU && s_resp_valid;
        m0_rdata       = (in_wait && owner == MID_IFU) ? s_rdata : '0;
        m1_rdata       = (in_wait && owner == MID_LSU) ? s_rdata : '0;
        s_resp_ready   = in_wait && own_resp_ready;
        busy           = state != IDLE;
    end

endmodule
